// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write-port arbiter for WB, MDU results and debug writes
// Also keeps the MDU result buffer, the busy-register scoreboard and the ID hazard stall.
module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_wa,
  input  logic [31:0] mdu_wd,
  output logic        mdu_ready,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_rd,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_wa,
  input  logic [31:0] dbg_wd,
  output logic        dbg_ack,
  input  logic [4:0]  id_ra0,
  input  logic [4:0]  id_ra1,
  input  logic        id_is_mdu,
  input  logic [4:0]  id_rd,
  output logic        hazard_stall,
  output logic        stall_req,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    buf_wa_q [2];
  logic [31:0]   buf_wd_q [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   busy_q, busy_d;

  logic        wb_real, pop, push, dbg_grant, keep, wr_idx;
  logic [4:0]  head_wa, other_wa;
  logic [31:0] head_wd, clr_mask, set_mask, eff_busy;

  assign head_wa  = buf_wa_q[rd_ptr_q];
  assign head_wd  = buf_wd_q[rd_ptr_q];
  assign other_wa = buf_wa_q[~rd_ptr_q];
  assign wr_idx   = rd_ptr_q ^ count_q[0];

  // Nothing reaches the register file while reset is held.
  assign wb_real   = !rst && wb_we && (wb_wa != 5'd0);
  assign pop       = !rst && !wb_real && (count_q != 2'd0);
  assign dbg_grant = !rst && dbg_we && !wb_real && !pop;
  assign dbg_ack   = dbg_grant;

  assign mdu_ready = (count_q != 2'd2);
  assign push      = mdu_valid && mdu_ready && (mdu_wa != 5'd0);

  // A popped register stays busy if another buffered or arriving result still targets it.
  assign keep     = ((count_q == 2'd2) && (other_wa == head_wa)) || (push && (mdu_wa == head_wa));
  assign clr_mask = (pop && !keep) ? (32'd1 << head_wa) : 32'd0;
  assign set_mask = (mdu_issue && (mdu_issue_rd != 5'd0)) ? (32'd1 << mdu_issue_rd) : 32'd0;
  assign busy_d   = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
  assign eff_busy = busy_q & ~clr_mask;

  assign hazard_stall = ((id_ra0 != 5'd0) && eff_busy[id_ra0]) ||
                        ((id_ra1 != 5'd0) && eff_busy[id_ra1]) ||
                        (id_is_mdu && (id_rd != 5'd0) && eff_busy[id_rd]);

  assign stall_req = (starve_q >= SW'(STARVE_LIMIT));

  always_comb begin
    rf_we = 1'b0;
    rf_wa = 5'd0;
    rf_wd = 32'd0;
    if (wb_real) begin
      rf_we = 1'b1;
      rf_wa = wb_wa;
      rf_wd = wb_wd;
    end else if (pop) begin
      rf_we = 1'b1;
      rf_wa = head_wa;
      rf_wd = head_wd;
    end else if (dbg_grant && (dbg_wa != 5'd0)) begin
      rf_we = 1'b1;
      rf_wa = dbg_wa;
      rf_wd = dbg_wd;
    end
  end

  always_comb begin
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    starve_d = starve_q;
    if (count_q == 2'd0 || pop) begin
      starve_d = '0;
    end else if (starve_q < SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      starve_q <= '0;
      busy_q   <= 32'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_wa_q[wr_idx] <= mdu_wa;
      buf_wd_q[wr_idx] <= mdu_wd;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we, mdu_valid, mdu_issue, dbg_we, id_is_mdu;
  logic [4:0]  wb_wa, mdu_wa, mdu_issue_rd, dbg_wa, id_ra0, id_ra1, id_rd;
  logic [31:0] wb_wd, mdu_wd, dbg_wd;
  logic        mdu_ready, dbg_ack, hazard_stall, stall_req, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .mdu_valid(mdu_valid), .mdu_wa(mdu_wa), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
    .dbg_we(dbg_we), .dbg_wa(dbg_wa), .dbg_wd(dbg_wd), .dbg_ack(dbg_ack),
    .id_ra0(id_ra0), .id_ra1(id_ra1), .id_is_mdu(id_is_mdu), .id_rd(id_rd),
    .hazard_stall(hazard_stall), .stall_req(stall_req),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    #1;
    chk({tag, ".we"}, 32'(rf_we), 32'(we));
    chk({tag, ".wa"}, 32'(rf_wa), 32'(wa));
    chk({tag, ".wd"}, rf_wd, wd);
  endtask

  initial begin
    rst = 1'b1;
    wb_we = 0; wb_wa = 0; wb_wd = 0;
    mdu_valid = 0; mdu_wa = 0; mdu_wd = 0;
    mdu_issue = 0; mdu_issue_rd = 0;
    dbg_we = 0; dbg_wa = 0; dbg_wd = 0;
    id_ra0 = 0; id_ra1 = 0; id_is_mdu = 0; id_rd = 0;
    tick();
    chk_rf("rst_rf", 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    chk_rf("idle_rf", 0, 0, 0);
    chk("idle_ready", 32'(mdu_ready), 1);
    chk("idle_stall", 32'(stall_req), 0);
    chk("idle_hazard", 32'(hazard_stall), 0);
    chk("idle_ack", 32'(dbg_ack), 0);

    // MDU issue x5, result one cycle later, forwarded read in write cycle
    mdu_issue = 1; mdu_issue_rd = 5;
    tick();
    mdu_issue = 0; id_ra0 = 5;
    mdu_valid = 1; mdu_wa = 5; mdu_wd = 32'h1234;
    #1;
    chk("x5_haz_before", 32'(hazard_stall), 1);
    chk("x5_ready", 32'(mdu_ready), 1);
    chk("x5_no_write_yet", 32'(rf_we), 0);
    tick();
    mdu_valid = 0;
    chk_rf("x5_write", 1, 5, 32'h1234);
    chk("x5_haz_fwd", 32'(hazard_stall), 0);
    tick();
    chk("x5_haz_after", 32'(hazard_stall), 0);
    chk("x5_rf_idle", 32'(rf_we), 0);
    id_ra0 = 0;

    // Fill buffer with x6, x7 under continuous WB traffic; starvation stall
    mdu_issue = 1; mdu_issue_rd = 6;
    tick();
    mdu_issue_rd = 7;
    tick();
    mdu_issue = 0;
    wb_we = 1; wb_wa = 1; wb_wd = 32'hAAAA;
    mdu_valid = 1; mdu_wa = 6; mdu_wd = 32'h66;
    tick();
    mdu_wa = 7; mdu_wd = 32'h77;
    #1;
    chk("fill_ready1", 32'(mdu_ready), 1);
    tick();
    mdu_valid = 0;
    chk_rf("full_wb", 1, 1, 32'hAAAA);
    chk("full_ready", 32'(mdu_ready), 0);
    chk("starve_c", 32'(stall_req), 0);
    tick();
    #1 chk("starve_d", 32'(stall_req), 0);
    tick();
    #1 chk("starve_e", 32'(stall_req), 0);
    tick();
    #1 chk("starve_f", 32'(stall_req), 1);
    wb_we = 0;
    chk_rf("bubble_x6", 1, 6, 32'h66);
    chk("bubble_ready", 32'(mdu_ready), 0);
    tick();
    chk_rf("then_x7", 1, 7, 32'h77);
    chk("stall_clear", 32'(stall_req), 0);
    chk("ready_again", 32'(mdu_ready), 1);
    tick();

    // WB x8 vs head x9 vs debug x10
    mdu_issue = 1; mdu_issue_rd = 9;
    tick();
    mdu_issue = 0;
    mdu_valid = 1; mdu_wa = 9; mdu_wd = 32'h99;
    tick();
    mdu_valid = 0;
    wb_we = 1; wb_wa = 8; wb_wd = 32'h88;
    dbg_we = 1; dbg_wa = 10; dbg_wd = 32'h1010;
    chk_rf("prio_wb", 1, 8, 32'h88);
    chk("prio_ack0", 32'(dbg_ack), 0);
    tick();
    wb_we = 0;
    chk_rf("prio_head", 1, 9, 32'h99);
    chk("prio_ack1", 32'(dbg_ack), 0);
    tick();
    chk_rf("prio_dbg", 1, 10, 32'h1010);
    chk("prio_ack2", 32'(dbg_ack), 1);
    tick();
    dbg_we = 0;
    #1 chk("ack_pulse_end", 32'(dbg_ack), 0);
    tick();

    // x0 targets: handshake/ack complete, no write, nothing buffered
    mdu_valid = 1; mdu_wa = 0; mdu_wd = 32'h5;
    wb_we = 1; wb_wa = 0; wb_wd = 32'hDEAD;
    chk_rf("x0_mdu", 0, 0, 0);
    chk("x0_ready", 32'(mdu_ready), 1);
    tick();
    mdu_valid = 0; wb_we = 0;
    dbg_we = 1; dbg_wa = 0; dbg_wd = 32'hBEEF;
    chk_rf("x0_dbg", 0, 0, 0);
    chk("x0_dbg_ack", 32'(dbg_ack), 1);
    tick();
    dbg_we = 0;
    chk_rf("x0_empty", 0, 0, 0);

    // Two buffered results to x11
    mdu_issue = 1; mdu_issue_rd = 11;
    tick();
    mdu_issue = 0;
    id_is_mdu = 1; id_rd = 11;
    wb_we = 1; wb_wa = 2; wb_wd = 32'h2;
    mdu_valid = 1; mdu_wa = 11; mdu_wd = 32'hB1;
    #1 chk("x11_haz_a", 32'(hazard_stall), 1);
    tick();
    mdu_wd = 32'hB2;
    tick();
    mdu_valid = 0; wb_we = 0;
    chk_rf("x11_pop1", 1, 11, 32'hB1);
    chk("x11_haz_pop1", 32'(hazard_stall), 1);
    tick();
    chk_rf("x11_pop2", 1, 11, 32'hB2);
    chk("x11_haz_pop2", 32'(hazard_stall), 0);
    tick();
    chk("x11_haz_done", 32'(hazard_stall), 0);
    id_is_mdu = 0; id_rd = 0;

    // Reset mid-operation discards buffer and scoreboard
    mdu_issue = 1; mdu_issue_rd = 12;
    tick();
    mdu_issue = 0;
    wb_we = 1; wb_wa = 3; wb_wd = 32'h3;
    mdu_valid = 1; mdu_wa = 12; mdu_wd = 32'hC;
    tick();
    mdu_valid = 0; wb_we = 0; rst = 1;
    chk_rf("rst_mid_rf", 0, 0, 0);
    tick();
    rst = 0; id_ra1 = 12;
    chk_rf("post_rst_rf", 0, 0, 0);
    chk("post_rst_haz", 32'(hazard_stall), 0);
    id_ra1 = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between the pipeline WB stage, the long-latency multiply/divide unit (MDU), and the debug bus. Holds MDU results in a 2-entry buffer, keeps a 32-bit scoreboard of registers with MDU results still pending, and raises an ID-stage hazard stall. Sits between WB/MDU/debug and the register file's wa/we/wd port.

## Interface
- STARVE_LIMIT, 4: consecutive cycles the buffer head may be blocked by WB before stall_req asserts (≥1).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_we / wb_wa / wb_wd  in  1/5/32  WB-stage write request; cannot be back-pressured.
- mdu_valid / mdu_wa / mdu_wd  in  1/5/32  MDU result offer.
- mdu_ready  out  1  buffer can accept this cycle.
- mdu_issue / mdu_issue_rd  in  1/5  MDU op leaving ID this cycle; marks its rd busy.
- dbg_we / dbg_wa / dbg_wd  in  1/5/32  debug write request, held until acked.
- dbg_ack  out  1  one-cycle pulse: debug write performed this cycle.
- id_ra0 / id_ra1  in  5/5  ID-stage source registers.
- id_is_mdu / id_rd  in  1/5  ID instruction is an MDU op / its destination.
- hazard_stall  out  1  ID must stall (RAW or WAW on a busy register).
- stall_req  out  1  pipeline must insert a WB bubble.
- rf_we / rf_wa / rf_wd  out  1/5/32  to register-file write port.

## Operation
- Write to x0 = no request: wb_we with wb_wa=0 leaves the port free; MDU results with mdu_wa=0 are accepted (handshake completes) but not buffered; debug writes to x0 are acked without rf_we.
- Grant priority per cycle, combinational: (1) WB valid request; (2) buffer head (popped); (3) debug (dbg_ack=1). rf_we=1 only for a granted real write; otherwise rf_we=0, rf_wa=0, rf_wd=0.
- Buffer: 2-entry FIFO of {wa, wd}, count 0..2. mdu_ready = (count≠2). Push on mdu_valid&&mdu_ready&&mdu_wa≠0. Push and pop in the same cycle are allowed; at count=2 a same-cycle pop does not raise mdu_ready.
- Starvation: starve_cnt increments each cycle the buffer is non-empty and the head is not popped; clears on pop or when empty; saturates at STARVE_LIMIT. stall_req = (starve_cnt ≥ STARVE_LIMIT).
- Scoreboard busy[31:1], busy[0] hard 0. Set on mdu_issue with rd≠0. Cleared when the buffer head writing rd pops, unless the other buffer entry also targets rd. On a same-cycle set and clear of one register, set wins.
- hazard_stall = any of: id_ra0≠0 && eff_busy[id_ra0]; id_ra1≠0 && eff_busy[id_ra1]; id_is_mdu && id_rd≠0 && eff_busy[id_rd]. eff_busy = busy with the bit for the register popped this cycle masked off, because the register file forwards same-cycle write data.
- Debug lowest priority. It can starve while the pipeline runs and is served on any free cycle.

## Timing
- Reset: buffer empty, count=0, starve_cnt=0, busy=0. Outputs: mdu_ready=1, stall_req=0, hazard_stall=0, dbg_ack=0, rf_we=0, rf_wa=0, rf_wd=0.
- Reset mid-operation discards buffered results and scoreboard bits with no write.
- WB and debug paths: 0 cycles, with rf_* combinational from inputs.
- MDU path: accepted at edge N, earliest write in cycle N+1. Busy clears at the edge that ends the write cycle.
- stall_req asserts in the cycle after starve_cnt reaches STARVE_LIMIT (registered count, combinational compare). It deasserts the cycle after the pop.
- All state updates on posedge clk.

## Test plan
- Reset, then idle → rf_we=0, mdu_ready=1, busy=0. sp/gp untouched (no rf_we during reset).
- mdu_issue rd=5; a later result wa=5, wd=0x1234 with WB idle → rf_we=1, wa=5, wd=0x1234 one cycle after accept. With id_ra0=5 in that cycle, hazard_stall=0; in the cycle before, it is 1.
- WB writes every cycle with 2 MDU results buffered (x6, x7) → mdu_ready=0 while full. stall_req=1 once the head is blocked for 4 cycles. On the bubble, x6 is written, then x7.
- Same cycle: WB x8, buffer head x9, debug x10 → x8 written; x9 next cycle; x10 then acked with a single dbg_ack pulse.
- MDU result with wa=0 and debug write with wa=0 → handshake/ack complete, rf_we never 1, count unchanged.
- Two buffered results both to x11 → busy[11] stays set after the first pop and clears after the second. id_is_mdu with id_rd=11 stalls until then.
